byte_reg_bank: RTL and testbench
================================

BYTE_REG_BANK -- requirements
Module: byte_reg_bank

Interface
REQ-001 Parameter NBYTES, default 4: byte lanes per entry; data width is 8*NBYTES.
REQ-002 Parameter DEPTH, default 8: number of entries, at least 2; ADDR_W = clog2(DEPTH).
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 resetn  in  1  asynchronous, active-high reset; asserted (1) forces reset state immediately.
REQ-005 wr_valid  in  1  write request.
REQ-006 wr_ready  out  1  write accepted when wr_valid and wr_ready are both 1 at a rising edge.
REQ-007 wr_addr  in  ADDR_W  write entry index.
REQ-008 wr_byteen  in  NBYTES  per-lane write mask, bit i selects D bits [8i+7:8i].
REQ-009 wr_data  in  8*NBYTES  write data.
REQ-010 rd_en  in  1  read request.
REQ-011 rd_addr  in  ADDR_W  read entry index.
REQ-012 rd_data  out  8*NBYTES  read data, registered.
REQ-013 rd_data_valid  out  1  one-cycle pulse qualifying rd_data.
REQ-014 clear_req  in  1  request to zero all entries.
REQ-015 busy  out  1  high while a clear sweep is in progress.
REQ-016 dirty  out  DEPTH  bit k set when entry k has been written since last reset or clear.

Function
REQ-017 Accepted write updates only the lanes of entry wr_addr whose wr_byteen bit is 1; other lanes and entries hold; wr_byteen all-zero updates no data but still sets dirty[wr_addr].
REQ-018 wr_addr >= DEPTH (non-power-of-two DEPTH) is dropped: no storage change, no dirty change.
REQ-019 Read latency is 1: rd_en at edge t yields rd_data and rd_data_valid=1 after edge t; rd_data holds its value when rd_en=0; rd_data_valid=0 otherwise.
REQ-020 Read and accepted write to the same address at the same edge return the merged (post-write) value (write-first).
REQ-021 FSM states IDLE and CLEAR; IDLE -> CLEAR on clear_req=1 at an edge; entering CLEAR sets sweep pointer to 0.
REQ-022 In CLEAR each edge zeroes entry ptr and clears dirty[ptr], then increments ptr; after entry DEPTH-1 is cleared, the FSM returns to IDLE; busy is high for exactly DEPTH cycles.
REQ-023 busy = (state == CLEAR); wr_ready = not busy; writes presented during CLEAR are not accepted.
REQ-024 clear_req while in CLEAR is ignored (no restart, no extension).
REQ-025 Write accepted at the same edge as clear_req in IDLE is performed, then erased by the sweep.
REQ-026 Reads are served during CLEAR; entries not yet swept return old contents; a read of entry ptr in the cycle it is cleared returns zero.

Reset
REQ-027 While resetn=1: all entries 0, dirty 0, rd_data 0, rd_data_valid 0, state IDLE, ptr 0, busy 0, wr_ready 1 once reset is released.
REQ-028 Reset asserted mid-sweep aborts the sweep; no partial state survives.

Structure
REQ-029 Shared package holds the FSM state typedef (IDLE, CLEAR) and the default NBYTES/DEPTH constants.
REQ-030 One sub-module, byte_reg_clear_seq, holds the FSM and sweep pointer and outputs busy, clear strobe and clear index; storage, merge, read path and dirty bits stay in byte_reg_bank.

Verification
REQ-031 Reset: assert resetn mid-operation -> rd_data=0, dirty=0, busy=0, wr_ready=1 after release.
REQ-032 Byte merge: write 0xAABBCCDD to entry 3 with byteen 4'b1111, then 0x11223344 with byteen 4'b0101 -> read of entry 3 returns 0xAA22CC44 one cycle after rd_en; dirty[3]=1.
REQ-033 Bypass: write 0x000000FF with byteen 4'b0001 to entry 5 (prior value 0x12345678) and read entry 5 at the same edge -> rd_data=0x123456FF.
REQ-034 Clear sweep: fill all 8 entries, pulse clear_req -> busy high for 8 cycles, wr_ready low over the same cycles, writes offered then are dropped, all entries read 0, dirty=0.
REQ-035 Clear collisions: clear_req together with a write to entry 0 -> entry 0 reads 0 after sweep; second clear_req during CLEAR -> busy still exactly 8 cycles.
REQ-036 Mid-sweep read: during CLEAR, read entry 7 before it is swept -> old value; read entry 7 in its sweep cycle -> 0.

Source files
------------

// File: rtl/byte_reg_bank_pkg.sv
// Shared types and default sizing for the byte-lane register bank.
// The clear sequencer FSM state type lives here so the bank, its debug port and benches agree.
package byte_reg_bank_pkg;

    localparam int DEF_NBYTES = 4;
    localparam int DEF_DEPTH  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/byte_reg_bank_if.sv
// Bus bundle for byte_reg_bank: write channel, read channel, clear control and status.
// Handshake: a write transfers on a rising edge where wr_valid and wr_ready are both 1; the master holds
// wr_addr/wr_byteen/wr_data stable while wr_valid is high, and wr_ready never depends on wr_valid.
interface byte_reg_bank_if
    import byte_reg_bank_pkg::*;
#(
    parameter int NBYTES = DEF_NBYTES,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int W      = 8 * NBYTES;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [NBYTES-1:0] wr_byteen;
    logic [W-1:0]      wr_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [W-1:0]      rd_data;
    logic              rd_data_valid;
    logic              clear_req;
    logic              busy;
    logic [DEPTH-1:0]  dirty;

    modport master (
        output wr_valid, wr_addr, wr_byteen, wr_data, rd_en, rd_addr, clear_req,
        input  wr_ready, rd_data, rd_data_valid, busy, dirty
    );

    modport slave (
        input  wr_valid, wr_addr, wr_byteen, wr_data, rd_en, rd_addr, clear_req,
        output wr_ready, rd_data, rd_data_valid, busy, dirty
    );

endinterface

// File: rtl/byte_reg_clear_seq.sv
// Clear sequencer: walks a pointer over every entry once per clear request.
// Emits one clear strobe per entry; requests arriving mid-sweep are ignored.
module byte_reg_clear_seq
    import byte_reg_bank_pkg::*;
#(
    parameter  int DEPTH  = DEF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              clear_req,
    output logic              busy,
    output logic              clr_stb,
    output logic [ADDR_W-1:0] clr_idx,
    output clr_state_t        state
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [ADDR_W-1:0] ptr;

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            state <= IDLE;
            ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear_req) begin
                        state <= CLEAR;
                        ptr   <= '0;
                    end
                end
                CLEAR: begin
                    if (ptr == LAST) begin
                        state <= IDLE;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                end
            endcase
        end
    end

    // Outputs come straight off the state and pointer flops.
    assign busy    = (state == CLEAR);
    assign clr_stb = (state == CLEAR);
    assign clr_idx = ptr;

endmodule

// File: rtl/byte_reg_bank.sv
// Register bank with per-byte write enables, write-first registered reads, dirty tracking
// and a background clear sweep driven by byte_reg_clear_seq.
module byte_reg_bank
    import byte_reg_bank_pkg::*;
#(
    parameter int NBYTES = DEF_NBYTES,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic             clock,
    input  logic             resetn,
    byte_reg_bank_if.slave   bus,
    output clr_state_t       dbg_state
);

    localparam int W      = 8 * NBYTES;
    localparam int ADDR_W = $clog2(DEPTH);

    logic [W-1:0]      mem [DEPTH];
    logic              busy;
    logic              clr_stb;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_ok;
    logic              rd_ok;
    logic              wr_hit;
    logic [W-1:0]      wr_old;
    logic [W-1:0]      wr_merged;
    logic [W-1:0]      rd_cur;
    logic [W-1:0]      rd_next;

    function automatic logic [W-1:0] merge_bytes(input logic [W-1:0]      old_d,
                                                 input logic [W-1:0]      new_d,
                                                 input logic [NBYTES-1:0] be);
        logic [W-1:0] r;
        r = old_d;
        for (int i = 0; i < NBYTES; i++) begin
            if (be[i]) r[8*i +: 8] = new_d[8*i +: 8];
        end
        return r;
    endfunction

    byte_reg_clear_seq #(.DEPTH(DEPTH)) u_clear_seq (
        .clock     (clock),
        .resetn    (resetn),
        .clear_req (bus.clear_req),
        .busy      (busy),
        .clr_stb   (clr_stb),
        .clr_idx   (clr_idx),
        .state     (dbg_state)
    );

    assign bus.busy     = busy;
    assign bus.wr_ready = ~busy;

    // Out-of-range addresses only exist for non-power-of-two DEPTH; such writes are dropped.
    always_comb begin
        wr_ok     = (32'(bus.wr_addr) < DEPTH);
        rd_ok     = (32'(bus.rd_addr) < DEPTH);
        wr_hit    = bus.wr_valid && bus.wr_ready && wr_ok;
        wr_old    = wr_ok ? mem[bus.wr_addr] : '0;
        rd_cur    = rd_ok ? mem[bus.rd_addr] : '0;
        wr_merged = merge_bytes(wr_old, bus.wr_data, bus.wr_byteen);
        rd_next   = rd_cur;
        if (clr_stb && (clr_idx == bus.rd_addr)) begin
            rd_next = '0;
        end else if (wr_hit && (bus.wr_addr == bus.rd_addr)) begin
            rd_next = wr_merged;
        end
    end

    // Sweep and accepted writes never coincide because wr_ready is low while busy.
    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
            bus.dirty <= '0;
        end else begin
            if (clr_stb) begin
                mem[clr_idx]       <= '0;
                bus.dirty[clr_idx] <= 1'b0;
            end
            if (wr_hit) begin
                mem[bus.wr_addr]       <= wr_merged;
                bus.dirty[bus.wr_addr] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge resetn) begin
        if (resetn) begin
            bus.rd_data       <= '0;
            bus.rd_data_valid <= 1'b0;
        end else begin
            bus.rd_data_valid <= bus.rd_en;
            if (bus.rd_en) bus.rd_data <= rd_next;
        end
    end

endmodule

// File: tb/tb_byte_reg_bank.sv
// Directed bench for byte_reg_bank: reads push expected words into a queue that a
// negedge monitor drains whenever rd_data_valid is high; status checks are done inline.
module tb_byte_reg_bank;
  import byte_reg_bank_pkg::*;

  localparam int NB = 4;
  localparam int DP = 8;

  logic clock;
  logic resetn;
  clr_state_t dbg_state;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];

  byte_reg_bank_if #(.NBYTES(NB), .DEPTH(DP)) bus ();

  byte_reg_bank #(.NBYTES(NB), .DEPTH(DP)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor / scoreboard
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clock);
      if (bus.rd_data_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rd_valid", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("rd_data", bus.rd_data, e);
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_byteen = '0;
    bus.wr_data   = '0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;
    bus.clear_req = 1'b0;
  endtask

  task automatic do_write(input int addr, input logic [3:0] be, input logic [31:0] data);
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 3'(addr);
    bus.wr_byteen = be;
    bus.wr_data   = data;
    tick();
    bus.wr_valid  = 1'b0;
  endtask

  task automatic do_read(input int addr, input logic [31:0] exp);
    bus.rd_en   = 1'b1;
    bus.rd_addr = 3'(addr);
    exp_q.push_back(exp);
    tick();
    bus.rd_en   = 1'b0;
  endtask

  // Pulse clear_req (optionally with a write), then count busy cycles while offering writes.
  task automatic run_clear(input bit with_write, input bit second_req, output int busy_cycles);
    int n;
    n = 0;
    bus.clear_req = 1'b1;
    if (with_write) begin
      bus.wr_valid  = 1'b1;
      bus.wr_addr   = 3'd0;
      bus.wr_byteen = 4'hF;
      bus.wr_data   = 32'h5555_5555;
    end
    tick();
    bus.clear_req = 1'b0;
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 3'd2;
    bus.wr_byteen = 4'hF;
    bus.wr_data   = 32'hDEAD_BEEF;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      bus.clear_req = 1'b0;
      if (bus.busy !== 1'b1) break;
      n++;
      check("wr_ready_low_in_clear", 32'(bus.wr_ready), 32'd0);
      if (second_req && n == 3) bus.clear_req = 1'b1;
    end
    bus.wr_valid  = 1'b0;
    bus.clear_req = 1'b0;
    #6;
    busy_cycles = n;
  endtask

  // stimulus
  initial begin
    int bc;
    idle_inputs();
    resetn = 1'b0;
    #1 resetn = 1'b1;
    #20;
    check("reset_rd_data", bus.rd_data, 32'h0);
    check("reset_rd_valid", 32'(bus.rd_data_valid), 32'd0);
    check("reset_dirty", 32'(bus.dirty), 32'd0);
    check("reset_busy", 32'(bus.busy), 32'd0);
    @(posedge clock);
    #1 resetn = 1'b0;
    #1;
    check("reset_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("reset_state", 32'(dbg_state), 32'(IDLE));

    // byte merge
    do_write(3, 4'b1111, 32'hAABB_CCDD);
    do_write(3, 4'b0101, 32'h1122_3344);
    do_read(3, 32'hAA22_CC44);
    check("dirty_after_merge", 32'(bus.dirty), 32'h0000_0008);

    // write-first bypass
    do_write(5, 4'b1111, 32'h1234_5678);
    bus.wr_valid  = 1'b1;
    bus.wr_addr   = 3'd5;
    bus.wr_byteen = 4'b0001;
    bus.wr_data   = 32'h0000_00FF;
    bus.rd_en     = 1'b1;
    bus.rd_addr   = 3'd5;
    exp_q.push_back(32'h1234_56FF);
    tick();
    idle_inputs();
    do_read(5, 32'h1234_56FF);
    tick();
    tick();
    check("rd_data_hold", bus.rd_data, 32'h1234_56FF);
    check("rd_valid_low", 32'(bus.rd_data_valid), 32'd0);

    // zero byteen: no data change, dirty still set
    do_write(6, 4'b0000, 32'hFFFF_FFFF);
    do_read(6, 32'h0);
    check("dirty_zero_be", 32'(bus.dirty), 32'h0000_0068);

    // fill and sweep
    for (int k = 0; k < DP; k++) do_write(k, 4'hF, 32'hA0A0_0000 | 32'(k));
    do_read(7, 32'hA0A0_0007);
    check("dirty_full", 32'(bus.dirty), 32'h0000_00FF);
    run_clear(1'b0, 1'b0, bc);
    check("busy_cycles", 32'(bc), 32'd8);
    check("dirty_after_clear", 32'(bus.dirty), 32'h0);
    for (int k = 0; k < DP; k++) do_read(k, 32'h0);

    // clear collisions: write at clear edge, second request mid-sweep
    run_clear(1'b1, 1'b1, bc);
    check("busy_cycles_second_req", 32'(bc), 32'd8);
    check("state_idle_after", 32'(dbg_state), 32'(IDLE));
    do_read(0, 32'h0);
    check("dirty_after_collision", 32'(bus.dirty), 32'h0);

    // mid-sweep read of entry 7
    do_write(7, 4'hF, 32'hCAFE_F00D);
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    do_read(7, 32'hCAFE_F00D);
    for (int i = 0; i < 5; i++) tick();
    do_read(7, 32'hCAFE_F00D);
    do_read(7, 32'h0);
    check("busy_end_sweep", 32'(bus.busy), 32'd0);
    do_read(7, 32'h0);

    // reset in the middle of a sweep
    do_write(1, 4'hF, 32'h0BAD_F00D);
    do_write(6, 4'hF, 32'h6666_6666);
    do_read(6, 32'h6666_6666);
    tick();
    bus.clear_req = 1'b1;
    tick();
    bus.clear_req = 1'b0;
    tick();
    #2 resetn = 1'b1;
    #1;
    check("midreset_rd_data", bus.rd_data, 32'h0);
    check("midreset_dirty", 32'(bus.dirty), 32'h0);
    check("midreset_busy", 32'(bus.busy), 32'd0);
    tick();
    resetn = 1'b0;
    #1;
    check("midreset_wr_ready", 32'(bus.wr_ready), 32'd1);
    check("midreset_state", 32'(dbg_state), 32'(IDLE));
    do_read(6, 32'h0);
    do_read(1, 32'h0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
